// File: rtl/compute_host_sequencer_if.sv
// Load stream, result stream and ComputeCoreWrapper control/data bus as seen
// by the host sequencer. master = sequencer side, slave = stream/wrapper side.
interface compute_host_sequencer_if;
  logic [63:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] control_low_word;
  logic [31:0] control_high_word;
  logic [31:0] dina_ext_low_word;
  logic [31:0] dina_ext_high_word;
  logic [31:0] dout_ext_low_word;
  logic [31:0] dout_ext_high_word;
  logic [31:0] status;

  modport master (
    input  in_data, in_valid, out_ready, dout_ext_low_word, dout_ext_high_word, status,
    output in_ready, out_data, out_valid, control_low_word, control_high_word,
           dina_ext_low_word, dina_ext_high_word
  );

  modport slave (
    output in_data, in_valid, out_ready, dout_ext_low_word, dout_ext_high_word, status,
    input  in_ready, out_data, out_valid, control_low_word, control_high_word,
           dina_ext_low_word, dina_ext_high_word
  );
endinterface

// File: rtl/compute_host_sequencer.sv
// Job sequencer in front of ComputeCoreWrapper: streams data and program words
// into the wrapper memories, runs the core until status[0], then streams a
// result window back out. Every output is driven straight from a flop.
module compute_host_sequencer #(
  parameter int unsigned PROG_BASE = 0,
  parameter int unsigned RD_LAT    = 2,
  parameter int unsigned TIMEOUT   = 1048575
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [9:0]                      data_len,
  input  logic [6:0]                      prog_len,
  input  logic [9:0]                      read_base,
  input  logic [9:0]                      read_len,
  compute_host_sequencer_if.master        bus,
  output logic                            busy,
  output logic                            done,
  output logic                            error
);

  typedef enum logic [2:0] {
    IDLE, LOAD_DATA, LOAD_PROG, CLR_WE, EXEC, RD_WAIT, RD_HOLD, FIN
  } state_t;

  localparam logic [5:0]  PBASE   = 6'(PROG_BASE);
  localparam logic [3:0]  LAT_CAP = 4'(RD_LAT);
  localparam logic [19:0] WD_LAST = 20'(TIMEOUT - 1);

  state_t      state, state_d;
  logic [9:0]  cnt, cnt_d;
  logic [19:0] wd, wd_d;
  logic [3:0]  lat, lat_d;
  logic [9:0]  dlen_q, dlen_d, rbase_q, rbase_d, rlen_q, rlen_d;
  logic [6:0]  plen_q, plen_d;
  logic        status0_q;

  logic [1:0]  ctrl_q, ctrl_d;
  logic        prog_sel_q, prog_sel_d, wea_q, wea_d;
  logic [9:0]  addr_q, addr_d;
  logic [63:0] dina_q, dina_d, out_data_q, out_data_d;
  logic        in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic        busy_q, busy_d, done_q, done_d, error_q, error_d;

  logic        hs;
  logic        status_unused;

  assign hs            = bus.in_valid & in_ready_q;
  assign status_unused = ^bus.status[31:1];

  // State, job registers and output flops; reset drops any job in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      wd          <= '0;
      lat         <= '0;
      dlen_q      <= '0;
      plen_q      <= '0;
      rbase_q     <= '0;
      rlen_q      <= '0;
      status0_q   <= 1'b0;
      ctrl_q      <= '0;
      prog_sel_q  <= 1'b0;
      wea_q       <= 1'b0;
      addr_q      <= '0;
      dina_q      <= '0;
      out_data_q  <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      wd          <= wd_d;
      lat         <= lat_d;
      dlen_q      <= dlen_d;
      plen_q      <= plen_d;
      rbase_q     <= rbase_d;
      rlen_q      <= rlen_d;
      status0_q   <= bus.status[0];
      ctrl_q      <= ctrl_d;
      prog_sel_q  <= prog_sel_d;
      wea_q       <= wea_d;
      addr_q      <= addr_d;
      dina_q      <= dina_d;
      out_data_q  <= out_data_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  // Next state and next output values; wrapper outputs appear one cycle after
  // the state that produced them.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    wd_d        = wd;
    lat_d       = lat;
    dlen_d      = dlen_q;
    plen_d      = plen_q;
    rbase_d     = rbase_q;
    rlen_d      = rlen_q;
    ctrl_d      = ctrl_q;
    prog_sel_d  = prog_sel_q;
    wea_d       = 1'b0;
    addr_d      = addr_q;
    dina_d      = dina_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    error_d     = 1'b0;
    case (state)
      IDLE: begin
        ctrl_d     = 2'd0;
        prog_sel_d = 1'b0;
        addr_d     = '0;
        if (start) begin
          if (prog_len == 7'd0 || prog_len > 7'd64) begin
            error_d = 1'b1;
          end else begin
            dlen_d  = data_len;
            plen_d  = prog_len;
            rbase_d = read_base;
            rlen_d  = read_len;
            cnt_d   = '0;
            state_d = (data_len == 10'd0) ? LOAD_PROG : LOAD_DATA;
          end
        end
      end
      LOAD_DATA: begin
        ctrl_d = 2'd1;
        if (hs) begin
          wea_d      = 1'b1;
          prog_sel_d = 1'b0;
          addr_d     = cnt;
          dina_d     = bus.in_data;
          if (cnt == dlen_q - 10'd1) begin
            cnt_d   = '0;
            state_d = LOAD_PROG;
          end else begin
            cnt_d = cnt + 10'd1;
          end
        end
      end
      LOAD_PROG: begin
        ctrl_d = 2'd1;
        if (hs) begin
          wea_d      = 1'b1;
          prog_sel_d = 1'b1;
          addr_d     = {4'b0, PBASE + cnt[5:0]};
          dina_d     = bus.in_data;
          if (cnt == {3'b0, plen_q} - 10'd1) begin
            cnt_d   = '0;
            state_d = CLR_WE;
          end else begin
            cnt_d = cnt + 10'd1;
          end
        end
      end
      CLR_WE: begin
        ctrl_d     = 2'd1;
        prog_sel_d = 1'b0;
        addr_d     = '0;
        wd_d       = '0;
        state_d    = EXEC;
      end
      EXEC: begin
        ctrl_d = 2'd2;
        if (status0_q) begin
          // Leave execute; first read address goes out with memory-access mode.
          ctrl_d = 2'd1;
          cnt_d  = '0;
          if (rlen_q == 10'd0) begin
            state_d = FIN;
          end else begin
            addr_d  = rbase_q;
            lat_d   = '0;
            state_d = RD_WAIT;
          end
        end else if (wd == WD_LAST) begin
          error_d = 1'b1;
          state_d = IDLE;
        end else begin
          wd_d = wd + 20'd1;
        end
      end
      RD_WAIT: begin
        ctrl_d = 2'd1;
        if (lat == LAT_CAP) begin
          out_data_d  = {bus.dout_ext_high_word, bus.dout_ext_low_word};
          out_valid_d = 1'b1;
          state_d     = RD_HOLD;
        end else begin
          lat_d = lat + 4'd1;
        end
      end
      RD_HOLD: begin
        // Single outstanding read: next address only after the consumer takes this word.
        ctrl_d = 2'd1;
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          if (cnt == rlen_q - 10'd1) begin
            state_d = FIN;
          end else begin
            cnt_d   = cnt + 10'd1;
            addr_d  = rbase_q + cnt + 10'd1;
            lat_d   = '0;
            state_d = RD_WAIT;
          end
        end
      end
      FIN: begin
        ctrl_d  = 2'd0;
        addr_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == LOAD_DATA) || (state_d == LOAD_PROG);
    busy_d     = (state_d != IDLE) && (state_d != FIN);
    done_d     = (state_d == FIN);
  end

  assign bus.control_low_word   = {20'b0, prog_sel_q, wea_q, addr_q};
  assign bus.control_high_word  = {30'b0, ctrl_q};
  assign bus.dina_ext_low_word  = dina_q[31:0];
  assign bus.dina_ext_high_word = dina_q[63:32];
  assign bus.in_ready           = in_ready_q;
  assign bus.out_valid          = out_valid_q;
  assign bus.out_data           = out_data_q;
  assign busy                   = busy_q;
  assign done                   = done_q;
  assign error                  = error_q;

endmodule
